// File: rtl/wishbone_pwm.sv
// Wishbone-slave PWM generator with double-buffered PERIOD/DUTY.
// New period/duty values are picked up only at a counter wrap, or continuously while disabled.
module wishbone_pwm #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0010,
  parameter int unsigned WIDTH     = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        en_i,
  output logic        pwm_o,
  output logic        period_done_o
);

  logic             hit, acc;
  logic [1:0]       reg_sel;
  logic [WIDTH-1:0] period_q, duty_q, period_d, duty_d;
  logic [WIDTH-1:0] period_sh_q, duty_sh_q, cnt_q;
  logic [31:0]      period_ext, duty_ext, rd_data;

  assign hit     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign acc     = hit & ~wbs_ack_o;
  assign reg_sel = wbs_adr_i[3:2];

  // Byte-lane merge of write data into the zero-extended current register value.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int n = 0; n < 4; n++) begin
      if (sel[n]) res[8*n +: 8] = wdat[8*n +: 8];
    end
    return res;
  endfunction

  always_comb begin
    period_ext = 32'(period_q);
    duty_ext   = 32'(duty_q);
    period_d   = period_q;
    duty_d     = duty_q;
    if (acc && wbs_we_i) begin
      if (reg_sel == 2'd0) period_d = WIDTH'(lane_merge(period_ext, wbs_dat_i, wbs_sel_i));
      if (reg_sel == 2'd1) duty_d   = WIDTH'(lane_merge(duty_ext, wbs_dat_i, wbs_sel_i));
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (reg_sel)
      2'd0: rd_data = period_ext;
      2'd1: rd_data = duty_ext;
      2'd2: rd_data = 32'(cnt_q);
      2'd3: rd_data = {30'b0, pwm_o, en_i};
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      period_q  <= '0;
      duty_q    <= '0;
    end else begin
      wbs_ack_o <= acc;
      if (acc) wbs_dat_o <= rd_data;
      period_q  <= period_d;
      duty_q    <= duty_d;
    end
  end

  // Shadows load from the pre-write register value, so a write landing on a wrap waits a period.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cnt_q         <= '0;
      period_sh_q   <= '0;
      duty_sh_q     <= '0;
      pwm_o         <= 1'b0;
      period_done_o <= 1'b0;
    end else if (!en_i) begin
      cnt_q         <= '0;
      period_sh_q   <= period_q;
      duty_sh_q     <= duty_q;
      pwm_o         <= 1'b0;
      period_done_o <= 1'b0;
    end else begin
      pwm_o <= (cnt_q < duty_sh_q);
      if (cnt_q == period_sh_q) begin
        cnt_q         <= '0;
        period_sh_q   <= period_q;
        duty_sh_q     <= duty_q;
        period_done_o <= 1'b1;
      end else begin
        cnt_q         <= cnt_q + WIDTH'(1);
        period_done_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wishbone_pwm.sv
// Directed bench for wishbone_pwm: read data checked by a queue-fed ack monitor,
// PWM waveform checked cycle by cycle against hand-derived period/duty patterns.
module tb_wishbone_pwm;

  localparam logic [31:0] Base = 32'h3000_0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat_w = '0, adr = '0;
  logic        ack;
  logic [31:0] dat_r;
  logic        en = 1'b0;
  logic        pwm, done;

  typedef struct packed {
    logic        chk;
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  wishbone_pwm #(.BASE_ADDR(Base), .WIDTH(16)) dut (
    .wb_clk_i      (clk),
    .wb_rst_n_i    (rst_n),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_dat_i     (dat_w),
    .wbs_adr_i     (adr),
    .wbs_ack_o     (ack),
    .wbs_dat_o     (dat_r),
    .en_i          (en),
    .pwm_o         (pwm),
    .period_done_o (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Ack monitor: every ack pops one expectation; acks must never be back to back.
  initial begin : monitor
    logic prev_ack;
    exp_t e;
    prev_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack) begin
        check("ack_single_cycle", {31'b0, prev_ack}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.chk) check($sformatf("read@%h", e.adr), dat_r, e.dat);
        end
      end
      prev_ack = ack;
    end
  end

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic chk, input logic [31:0] exp);
    int lat;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    exp_q.push_back(exp_t'{chk, a, exp});
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ack && lat < 4);
    check($sformatf("ack_latency@%h", a), 32'(lat), 32'd1);
    if (!ack) void'(exp_q.pop_back());
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wb_xfer(1'b1, a, d, s, 1'b0, 32'd0);
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] exp);
    wb_xfer(1'b0, a, 32'd0, 4'hf, 1'b1, exp);
  endtask

  // Edge k after enable: pwm reflects cnt=(k-1)%(per+1) against the duty in force; wrap every per+1.
  task automatic pwm_window(input int cycles, input int per, input int d0, input int d1,
                            input int switch_k, input string tag);
    int d;
    logic exp_pwm, exp_done;
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk);
      #1;
      d        = (k <= switch_k) ? d0 : d1;
      exp_pwm  = (((k - 1) % (per + 1)) < d);
      exp_done = ((k % (per + 1)) == 0);
      check($sformatf("%s_pwm_k%0d", tag, k), {31'b0, pwm}, {31'b0, exp_pwm});
      check($sformatf("%s_done_k%0d", tag, k), {31'b0, done}, {31'b0, exp_done});
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    #2;
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_pwm", {31'b0, pwm}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_dat", dat_r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    wb_read(Base + 32'h0, 32'd0);
    wb_read(Base + 32'h4, 32'd0);
    wb_read(Base + 32'h8, 32'd0);
    wb_read(Base + 32'hC, 32'd0);

    wb_write(Base + 32'h0, 32'hAABB_CCDD, 4'b0010);
    wb_read(Base + 32'h0, 32'h0000_CC00);

    wb_write(Base + 32'h0, 32'd9, 4'hf);
    wb_write(Base + 32'h4, 32'd3, 4'hf);
    wb_read(Base + 32'h0, 32'd9);
    wb_read(Base + 32'h4, 32'd3);

    // Duty rewritten to 7 early in the first period; it must not show until after the wrap.
    @(negedge clk);
    en = 1'b1;
    fork
      pwm_window(30, 9, 3, 7, 10, "dbuf");
      begin
        repeat (3) @(posedge clk);
        wb_write(Base + 32'h4, 32'd7, 4'hf);
      end
    join

    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("dis_pwm", {31'b0, pwm}, 32'd0);
    check("dis_done", {31'b0, done}, 32'd0);
    wb_read(Base + 32'h8, 32'd0);
    wb_read(Base + 32'hC, 32'd0);

    wb_write(Base + 32'h4, 32'd0, 4'hf);
    @(negedge clk);
    en = 1'b1;
    pwm_window(20, 9, 0, 0, 20, "duty0");
    @(negedge clk);
    en = 1'b0;

    wb_write(Base + 32'h4, 32'd20, 4'hf);
    @(negedge clk);
    en = 1'b1;
    pwm_window(20, 9, 20, 20, 20, "duty20");
    wb_read(Base + 32'hC, 32'd3);

    // Outside the window: never acked.
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = Base + 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("oow_ack_%0d", i), {31'b0, ack}, 32'd0);
    end
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0;

    // Held strobe acks every other cycle.
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = Base + 32'h4;
    exp_q.push_back(exp_t'{1'b1, Base + 32'h4, 32'd20});
    exp_q.push_back(exp_t'{1'b1, Base + 32'h4, 32'd20});
    check("hold_ack_0", {31'b0, ack}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_ack_%0d", i), {31'b0, ack}, {31'b0, (i % 2) == 1});
    end
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0;

    // Async reset while ack and pwm are high.
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = Base + 32'hC;
    exp_q.push_back(exp_t'{1'b1, Base + 32'hC, 32'd3});
    @(posedge clk);
    #2;
    check("pre_rst_ack", {31'b0, ack}, 32'd1);
    check("pre_rst_pwm", {31'b0, pwm}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_ack", {31'b0, ack}, 32'd0);
    check("async_rst_pwm", {31'b0, pwm}, 32'd0);
    check("async_rst_dat", dat_r, 32'd0);
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wb_read(Base + 32'h0, 32'd0);
    wb_read(Base + 32'h4, 32'd0);
    wb_read(Base + 32'h8, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
